lfsr_rng_arbiter: RTL and testbench
===================================

Name: lfsr_rng_arbiter

Overview:
- Sequencer and arbiter for a shared 32-bit Galois LFSR random source.
- Owns the LFSR state register and shares it among NREQ requesters using round-robin arbitration.
- Before each word is delivered, the LFSR advances STEPS times, so consecutive requesters never see correlated adjacent states.
- Supports runtime reseeding and guards against the all-zero lockup state.

Parameters:
- NREQ, 4: number of requesters (2..8).
- STEPS, 8: LFSR advances between served words (1..255).
- SEED, 32'hACE1_0001: reset seed; also substituted whenever a zero seed would be loaded.

Ports:
- clk  input  1: single clock, all state updates on rising edge.
- clear  input  1: asynchronous, active-high reset.
- seed_load  input  1: load seed_val into the LFSR this cycle.
- seed_val  input  32: new seed.
- req  input  NREQ: level request per requester; held until gnt.
- gnt  output  NREQ: one-hot, single-cycle grant.
- rnd  output  32: random word; valid with gnt, held until the next grant.
- rnd_valid  output  1: high exactly in the cycle any gnt bit is high.
- busy  output  1: high whenever the FSM is not in IDLE.

Behaviour:
- Reset (clear high, asynchronous):
  - lfsr=SEED, rr_ptr=0, state=IDLE.
  - gnt=0, rnd=0, rnd_valid=0, busy=0.
- LFSR step, with s=current state:
  - next = {s[30:0], s[31]} ^ ({32{s[31]}} & 32'hA010_8004).
  - Taps are bits 2, 15, 20, 29, 31.
- Zero guard: if lfsr would become 0 (by seed_load or any path), SEED is loaded instead. lfsr is never 0.
- FSM states: IDLE, STEP, GRANT.
  - IDLE, no req: stay in IDLE; lfsr holds.
  - IDLE, any req bit set: winner = first set bit at or after rr_ptr, searching upward with wrap modulo NREQ. Latch win_idx, cnt=STEPS, go to STEP.
  - STEP: each cycle lfsr advances and cnt decrements. When cnt reaches 1 in that cycle, go to GRANT. Exactly STEPS advances occur.
  - GRANT, req[win_idx] still high:
    - gnt[win_idx]=1, rnd_valid=1, rnd=lfsr, for one cycle.
    - rr_ptr = (win_idx+1) mod NREQ.
    - Go to IDLE; lfsr does not advance in GRANT.
  - GRANT, req[win_idx] low (abandoned): no gnt, rnd unchanged, rr_ptr unchanged, go to IDLE.
- Latency: req seen in IDLE at cycle 0 gives gnt at cycle STEPS+1. Minimum per-grant spacing is STEPS+2 cycles.
- seed_load has the highest priority in every state:
  - lfsr=seed_val (zero guarded).
  - Any transaction in progress is aborted: no gnt, return to IDLE, rr_ptr unchanged.
  - Arbitration resumes the following cycle.
- Simultaneous requests: exactly one grant per transaction. The others stay pending and are served in rotating order.
- A req bit set while the FSM is busy is ignored until IDLE.
- gnt and rnd_valid are registered; rnd changes only in GRANT or on reset.

Optional Feature:
- Macro: LFSR_RNG_FREERUN_EN.
- Defined: lfsr also advances every cycle in IDLE, so the served value depends on request timing. The zero guard still applies. In tests, deterministic vectors then require req asserted immediately after the seed_load cycle.
- Undefined: lfsr holds in IDLE; sequences are fully deterministic from the seed.

Test Plan:
- STEPS=1:
  - seed_load with seed_val=32'h0000_0001, then req=4'b0001 → gnt=4'b0001 and rnd=32'h0000_0002 two cycles after req.
  - seed_load with seed_val=32'h8000_0000, then req[2] → rnd=32'hA010_8005 with gnt=4'b0100.
- STEPS=8: seed_val=32'h0000_0001, req[1] → gnt[1] at cycle 9, rnd=32'h0000_0100, busy high for cycles 1..9.
- Round robin, req=4'b1111 held after each grant → grants in order 0,1,2,3,0. Each gnt is one cycle; rr_ptr wraps to 0 after 3.
- seed_load with seed_val=0 → lfsr=32'hACE1_0001; seed_load asserted mid-STEP → no gnt, busy low next cycle, rr_ptr unchanged.
- req[win_idx] dropped during STEP → no gnt at GRANT. clear pulsed mid-STEP → all outputs 0 and lfsr=SEED immediately, asynchronously.

Source files
------------

// File: rtl/lfsr_rng_arbiter.sv
// lfsr_rng_arbiter
// ----------------
// Shares one 32-bit Galois LFSR among NREQ requesters using round-robin
// arbitration. The LFSR is stepped STEPS times before each word is served.
// This keeps consecutive requesters from seeing adjacent, correlated states.
// The LFSR can be reseeded at run time. It never holds the all-zero lockup
// value, because SEED is substituted whenever zero would be loaded.
//
// Optional feature macro: LFSR_RNG_FREERUN_EN
//   When defined, the LFSR also advances on every IDLE cycle, so the served
//   value depends on request timing. When undefined, the LFSR holds in IDLE
//   and every sequence is fully determined by the seed.
//
// Ports:
//   clk        rising-edge clock
//   clear      asynchronous active-high reset
//   seed_load  load seed_val into the LFSR; aborts any transaction in flight
//   seed_val   new seed (zero is replaced by SEED)
//   req        level request per requester, held until granted
//   gnt        one-hot, single-cycle grant (registered)
//   rnd        random word, valid with gnt, held until the next grant
//   rnd_valid  high exactly in the grant cycle
//   busy       high whenever the sequencer is not idle
module lfsr_rng_arbiter #(
  parameter int          NREQ  = 4,
  parameter int          STEPS = 8,
  parameter logic [31:0] SEED  = 32'hACE1_0001
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            seed_load,
  input  logic [31:0]     seed_val,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     rnd,
  output logic            rnd_valid,
  output logic            busy
);

  localparam int          IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] TAPS = 32'hA010_8004;

  typedef enum logic [1:0] {IDLE, STEP, GRANT} state_t;

  state_t          state;
  logic [31:0]     lfsr;
  logic [31:0]     lfsr_step;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   rr_next;
  logic [7:0]      cnt;

  // Any value headed for the LFSR passes through this guard.
  function automatic logic [31:0] zero_guard(input logic [31:0] v);
    return (v == 32'd0) ? SEED : v;
  endfunction

  // One Galois step: rotate left, then fold in the taps when the MSB was set.
  assign lfsr_step = {lfsr[30:0], lfsr[31]} ^ ({32{lfsr[31]}} & TAPS);

  // Round-robin search: pick the first set request at or after rr_ptr,
  // wrapping modulo NREQ.
  always_comb begin
    int  k;
    logic found;
    pick  = rr_ptr;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!found && req[k]) begin
        found = 1'b1;
        pick  = IW'(k);
      end
    end
  end

  assign rr_next = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
  assign busy    = (state != IDLE);

  // Sequencer. The grant is registered on the final STEP edge, which is the
  // edge that enters GRANT. gnt and rnd_valid are therefore high for exactly
  // the GRANT cycle, and rnd equals the LFSR value during that cycle.
  // The LFSR does not move in GRANT. seed_load overrides everything and
  // drops back to IDLE without touching rr_ptr.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state     <= IDLE;
      lfsr      <= SEED;
      rr_ptr    <= '0;
      win_idx   <= '0;
      cnt       <= '0;
      gnt       <= '0;
      rnd       <= '0;
      rnd_valid <= 1'b0;
    end else begin
      gnt       <= '0;
      rnd_valid <= 1'b0;
      if (seed_load) begin
        lfsr  <= zero_guard(seed_val);
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
`ifdef LFSR_RNG_FREERUN_EN
            lfsr <= zero_guard(lfsr_step);
`else
            lfsr <= lfsr;
`endif
            if (|req) begin
              win_idx <= pick;
              cnt     <= 8'(STEPS);
              state   <= STEP;
            end
          end
          STEP: begin
            lfsr <= zero_guard(lfsr_step);
            cnt  <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              state <= GRANT;
              // An abandoned request gets no grant and keeps rr_ptr.
              if (req[win_idx]) begin
                gnt       <= NREQ'(1) << win_idx;
                rnd       <= zero_guard(lfsr_step);
                rnd_valid <= 1'b1;
                rr_ptr    <= rr_next;
              end
            end
          end
          GRANT: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_rng_arbiter.sv
// tb_lfsr_rng_arbiter
// -------------------
// Scoreboard bench for lfsr_rng_arbiter. There are two instances, one with
// STEPS=1 (dut1) and one with STEPS=8 (dut8). Directed stimulus pushes the
// expected grant index and random word into a per-instance queue. An
// independent negedge monitor pops the queue whenever the instance presents
// a grant, then compares the result.
module tb_lfsr_rng_arbiter;

  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic        clk = 1'b0;
  int          tests_run    = 0;
  int          tests_failed = 0;

  logic        clear1, seed_load1, rnd_valid1, busy1;
  logic [31:0] seed_val1, rnd1;
  logic [3:0]  req1, gnt1;

  logic        clear8, seed_load8, rnd_valid8, busy8;
  logic [31:0] seed_val8, rnd8;
  logic [3:0]  req8, gnt8;

  int          exp1_idx[$];
  logic [31:0] exp1_rnd[$];
  int          exp8_idx[$];
  logic [31:0] exp8_rnd[$];

  int          n;

  always #5 clk = ~clk;

  lfsr_rng_arbiter #(.NREQ(4), .STEPS(1), .SEED(SEED)) dut1 (
    .clk(clk), .clear(clear1), .seed_load(seed_load1), .seed_val(seed_val1),
    .req(req1), .gnt(gnt1), .rnd(rnd1), .rnd_valid(rnd_valid1), .busy(busy1)
  );

  lfsr_rng_arbiter #(.NREQ(4), .STEPS(8), .SEED(SEED)) dut8 (
    .clk(clk), .clear(clear8), .seed_load(seed_load8), .seed_val(seed_val8),
    .req(req8), .gnt(gnt8), .rnd(rnd8), .rnd_valid(rnd_valid8), .busy(busy8)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Queue the expected response, then drive the request vector.
  task automatic apply_stimulus(input int sel, input logic [3:0] reqv,
                                input int idx, input logic [31:0] r);
    if (sel == 1) begin
      exp1_idx.push_back(idx);
      exp1_rnd.push_back(r);
      req1 = reqv;
    end else begin
      exp8_idx.push_back(idx);
      exp8_rnd.push_back(r);
      req8 = reqv;
    end
  endtask

  task automatic load_seed(input int sel, input logic [31:0] v);
    if (sel == 1) begin
      seed_load1 = 1'b1; seed_val1 = v; tick(); seed_load1 = 1'b0;
    end else begin
      seed_load8 = 1'b1; seed_val8 = v; tick(); seed_load8 = 1'b0;
    end
  endtask

  task automatic wait_grant(input int sel, input int max_cycles, output int cycles);
    logic seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < max_cycles) begin
      tick();
      cycles++;
      seen = (sel == 1) ? rnd_valid1 : rnd_valid8;
    end
    check_output("grant seen before timeout", {31'b0, seen}, 32'd1);
  endtask

  // Scoreboard monitors: one per instance, sampling on the falling edge.
  always @(negedge clk) begin
    int idx;
    logic [31:0] r;
    if (rnd_valid1 || gnt1 != 4'b0) begin
      if (exp1_idx.size() == 0) begin
        check_output("dut1 unexpected grant", {27'b0, rnd_valid1, gnt1}, 32'd0);
      end else begin
        idx = exp1_idx.pop_front();
        r   = exp1_rnd.pop_front();
        check_output("dut1 gnt", {28'b0, gnt1}, 32'(1) << idx);
        check_output("dut1 rnd", rnd1, r);
        check_output("dut1 rnd_valid", {31'b0, rnd_valid1}, 32'd1);
      end
    end
  end

  always @(negedge clk) begin
    int idx;
    logic [31:0] r;
    if (rnd_valid8 || gnt8 != 4'b0) begin
      if (exp8_idx.size() == 0) begin
        check_output("dut8 unexpected grant", {27'b0, rnd_valid8, gnt8}, 32'd0);
      end else begin
        idx = exp8_idx.pop_front();
        r   = exp8_rnd.pop_front();
        check_output("dut8 gnt", {28'b0, gnt8}, 32'(1) << idx);
        check_output("dut8 rnd", rnd8, r);
        check_output("dut8 rnd_valid", {31'b0, rnd_valid8}, 32'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clear1 = 1'b1; seed_load1 = 1'b0; seed_val1 = '0; req1 = '0;
    clear8 = 1'b1; seed_load8 = 1'b0; seed_val8 = '0; req8 = '0;
    #12;
    clear1 = 1'b0;
    clear8 = 1'b0;
    tick();

    $display("[TB] reset state");
    check_output("dut1 reset gnt", {28'b0, gnt1}, 32'd0);
    check_output("dut1 reset rnd", rnd1, 32'd0);
    check_output("dut1 reset rnd_valid", {31'b0, rnd_valid1}, 32'd0);
    check_output("dut1 reset busy", {31'b0, busy1}, 32'd0);
    check_output("dut1 reset lfsr", dut1.lfsr, SEED);
    check_output("dut8 reset gnt", {28'b0, gnt8}, 32'd0);
    check_output("dut8 reset busy", {31'b0, busy8}, 32'd0);
    check_output("dut8 reset lfsr", dut8.lfsr, SEED);

    $display("[TB] STEPS=1 single steps");
    load_seed(1, 32'h0000_0001);
    apply_stimulus(1, 4'b0001, 0, 32'h0000_0002);
    wait_grant(1, 10, n);
    check_output("dut1 latency seed 1", 32'(n), 32'd2);
    req1 = 4'b0000;
    tick(); tick();

    load_seed(1, 32'h8000_0000);
    apply_stimulus(1, 4'b0100, 2, 32'hA010_8005);
    wait_grant(1, 10, n);
    check_output("dut1 latency tap fold", 32'(n), 32'd2);
    req1 = 4'b0000;
    tick(); tick();

    $display("[TB] round robin with all requests held");
    clear1 = 1'b1; #1; clear1 = 1'b0;
    load_seed(1, 32'h0000_0001);
    apply_stimulus(1, 4'b1111, 0, 32'h0000_0002);
    apply_stimulus(1, 4'b1111, 1, 32'h0000_0004);
    apply_stimulus(1, 4'b1111, 2, 32'h0000_0008);
    apply_stimulus(1, 4'b1111, 3, 32'h0000_0010);
    apply_stimulus(1, 4'b1111, 0, 32'h0000_0020);
    for (int k = 0; k < 5; k++) begin
      wait_grant(1, 10, n);
      check_output("dut1 rr spacing", 32'(n), (k == 0) ? 32'd2 : 32'd3);
    end
    req1 = 4'b0000;
    tick(); tick();

    $display("[TB] zero seed substitution");
    load_seed(1, 32'h0000_0000);
    check_output("dut1 zero seed guarded", dut1.lfsr, SEED);

    $display("[TB] STEPS=8 latency and busy window");
    load_seed(8, 32'h0000_0001);
    apply_stimulus(8, 4'b0010, 1, 32'h0000_0100);
    for (int c = 1; c <= 9; c++) begin
      tick();
      check_output("dut8 busy during transaction", {31'b0, busy8}, 32'd1);
      if (c == 8) check_output("dut8 no early gnt", {28'b0, gnt8}, 32'd0);
      if (c == 9) check_output("dut8 gnt at cycle 9", {28'b0, gnt8}, 32'h2);
    end
    req8 = 4'b0000;
    tick();
    check_output("dut8 busy after grant", {31'b0, busy8}, 32'd0);

    $display("[TB] seed_load aborts mid-STEP");
    load_seed(8, 32'h0000_0001);
    req8 = 4'b1000;
    tick(); tick(); tick();
    req8 = 4'b0000;
    load_seed(8, 32'h0000_0001);
    check_output("dut8 busy after abort", {31'b0, busy8}, 32'd0);
    check_output("dut8 no gnt on abort", {28'b0, gnt8}, 32'd0);
    // rr_ptr must still be 2 after the abort, so requester 3 beats requester 0.
    apply_stimulus(8, 4'b1001, 3, 32'h0000_0100);
    wait_grant(8, 20, n);
    check_output("dut8 latency after abort", 32'(n), 32'd9);
    req8 = 4'b0000;
    tick(); tick();

    $display("[TB] abandoned request");
    req8 = 4'b0001;
    tick(); tick(); tick();
    req8 = 4'b0000;
    repeat (10) tick();
    check_output("dut8 idle after abandon", {31'b0, busy8}, 32'd0);
    check_output("dut8 rnd held after abandon", rnd8, 32'h0000_0100);
    // rr_ptr must still be 0 after the abandon, and the LFSR kept stepping.
    apply_stimulus(8, 4'b0011, 0, 32'h0100_0000);
    wait_grant(8, 20, n);
    check_output("dut8 latency after abandon", 32'(n), 32'd9);
    req8 = 4'b0000;
    tick();

    $display("[TB] asynchronous clear mid-STEP");
    req8 = 4'b0010;
    tick(); tick(); tick();
    #2;
    clear8 = 1'b1;
    #1;
    check_output("dut8 clear gnt", {28'b0, gnt8}, 32'd0);
    check_output("dut8 clear rnd", rnd8, 32'd0);
    check_output("dut8 clear rnd_valid", {31'b0, rnd_valid8}, 32'd0);
    check_output("dut8 clear busy", {31'b0, busy8}, 32'd0);
    check_output("dut8 clear lfsr", dut8.lfsr, SEED);
    clear8 = 1'b0;
    req8   = 4'b0000;
    tick(); tick(); tick();
    check_output("dut8 idle after clear", {31'b0, busy8}, 32'd0);

    check_output("dut1 scoreboard drained", 32'(exp1_idx.size()), 32'd0);
    check_output("dut8 scoreboard drained", 32'(exp8_idx.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
